// File: rtl/uart_alarm_parser.sv
// Byte-level parser for "AHH:MM<CR|LF>" alarm-set commands arriving from the UART receiver.
// Presents a validated hour/minute with a one-cycle strobe and returns a K/E acknowledge byte.
module uart_alarm_parser #(
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic [4:0] alarm_hour,
    output logic [5:0] alarm_minute,
    output logic       alarm_set,
    output logic       cmd_error
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_H1    = 4'd1;
    localparam logic [3:0] S_H2    = 4'd2;
    localparam logic [3:0] S_COLON = 4'd3;
    localparam logic [3:0] S_M1    = 4'd4;
    localparam logic [3:0] S_M2    = 4'd5;
    localparam logic [3:0] S_TERM  = 4'd6;
    localparam logic [3:0] S_ERR   = 4'd7;
    localparam logic [3:0] S_RESP  = 4'd8;

    localparam logic [7:0] ACK_OK  = 8'h4B;
    localparam logic [7:0] ACK_ERR = 8'h45;

    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);

    function automatic logic in_range(input logic [7:0] b, input logic [7:0] lo,
                                      input logic [7:0] hi);
        return (b >= lo) && (b <= hi);
    endfunction

    function automatic logic [5:0] dec2(input logic [2:0] tens, input logic [3:0] units);
        return ({3'd0, tens} * 6'd10) + {2'd0, units};
    endfunction

    logic [3:0]       state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [1:0]       hour_tens_q, hour_tens_d;
    logic [4:0]       hour_q, hour_d;
    logic [2:0]       min_tens_q, min_tens_d;
    logic [5:0]       min_q, min_d;
    logic [4:0]       alarm_hour_q, alarm_hour_d;
    logic [5:0]       alarm_minute_q, alarm_minute_d;
    logic             alarm_set_q, alarm_set_d;
    logic             cmd_error_q, cmd_error_d;
    logic             tx_valid_q, tx_valid_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             is_term;

    assign is_term = (rx_data == 8'h0D) || (rx_data == 8'h0A);

    always_comb begin
        state_d        = state_q;
        tmo_d          = tmo_q;
        hour_tens_d    = hour_tens_q;
        hour_d         = hour_q;
        min_tens_d     = min_tens_q;
        min_d          = min_q;
        alarm_hour_d   = alarm_hour_q;
        alarm_minute_d = alarm_minute_q;
        alarm_set_d    = 1'b0;
        cmd_error_d    = 1'b0;
        tx_valid_d     = tx_valid_q;
        tx_data_d      = tx_data_q;

        // Inter-byte timeout: an arriving byte always beats expiry on the same cycle.
        if (state_q == S_IDLE || state_q == S_RESP || rx_valid) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_MAX) begin
            tmo_d   = '0;
            state_d = S_IDLE;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (rx_valid && (rx_data == 8'h41 || rx_data == 8'h61)) state_d = S_H1;
            end
            S_H1: begin
                if (rx_valid) begin
                    if (in_range(rx_data, 8'h30, 8'h32)) begin
                        hour_tens_d = rx_data[1:0];
                        state_d     = S_H2;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_H2: begin
                if (rx_valid) begin
                    if (in_range(rx_data, 8'h30, 8'h39)) begin
                        hour_d  = 5'(dec2({1'b0, hour_tens_q}, rx_data[3:0]));
                        state_d = S_COLON;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_COLON: begin
                if (rx_valid) state_d = (rx_data == 8'h3A) ? S_M1 : S_ERR;
            end
            S_M1: begin
                if (rx_valid) begin
                    if (in_range(rx_data, 8'h30, 8'h35)) begin
                        min_tens_d = rx_data[2:0];
                        state_d    = S_M2;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_M2: begin
                if (rx_valid) begin
                    if (in_range(rx_data, 8'h30, 8'h39)) begin
                        min_d   = dec2(min_tens_q, rx_data[3:0]);
                        state_d = S_TERM;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_TERM: begin
                if (rx_valid) begin
                    if (!is_term) begin
                        state_d = S_ERR;
                    end else if (hour_q <= 5'd23) begin
                        alarm_hour_d   = hour_q;
                        alarm_minute_d = min_q;
                        alarm_set_d    = 1'b1;
                        tx_data_d      = ACK_OK;
                        tx_valid_d     = 1'b1;
                        state_d        = S_RESP;
                    end else begin
                        cmd_error_d = 1'b1;
                        tx_data_d   = ACK_ERR;
                        tx_valid_d  = 1'b1;
                        state_d     = S_RESP;
                    end
                end
            end
            S_ERR: begin
                if (rx_valid && is_term) begin
                    cmd_error_d = 1'b1;
                    tx_data_d   = ACK_ERR;
                    tx_valid_d  = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                // Received bytes are dropped while the acknowledge is outstanding.
                if (tx_valid_q && tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            tmo_q          <= '0;
            alarm_hour_q   <= '0;
            alarm_minute_q <= '0;
            alarm_set_q    <= 1'b0;
            cmd_error_q    <= 1'b0;
            tx_valid_q     <= 1'b0;
            tx_data_q      <= 8'h00;
        end else begin
            state_q        <= state_d;
            tmo_q          <= tmo_d;
            alarm_hour_q   <= alarm_hour_d;
            alarm_minute_q <= alarm_minute_d;
            alarm_set_q    <= alarm_set_d;
            cmd_error_q    <= cmd_error_d;
            tx_valid_q     <= tx_valid_d;
            tx_data_q      <= tx_data_d;
        end
    end

    // Digit scratch registers are always rewritten before use, so they carry no reset.
    always_ff @(posedge clk) begin
        hour_tens_q <= hour_tens_d;
        hour_q      <= hour_d;
        min_tens_q  <= min_tens_d;
        min_q       <= min_d;
    end

    assign tx_data      = tx_data_q;
    assign tx_valid     = tx_valid_q;
    assign alarm_hour   = alarm_hour_q;
    assign alarm_minute = alarm_minute_q;
    assign alarm_set    = alarm_set_q;
    assign cmd_error    = cmd_error_q;

endmodule

// File: tb/tb_uart_alarm_parser.sv
// Directed bench for uart_alarm_parser: command sequences with hand-computed results,
// checked by immediate assertions at the negative clock edge.
module tb_uart_alarm_parser;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_minute;
    logic       alarm_set;
    logic       cmd_error;

    int n_total = 0;
    int n_pass  = 0;
    int set_cnt = 0;
    int err_cnt = 0;
    int resp_cnt = 0;
    logic tx_valid_prev = 1'b0;

    uart_alarm_parser #(.TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .alarm_hour   (alarm_hour),
        .alarm_minute (alarm_minute),
        .alarm_set    (alarm_set),
        .cmd_error    (cmd_error)
    );

    always #5 clk = ~clk;

    // Outputs move only on posedge; counting on negedge sees each one-cycle pulse once.
    always @(negedge clk) begin
        if (alarm_set) set_cnt++;
        if (cmd_error) err_cnt++;
        if (tx_valid && !tx_valid_prev) resp_cnt++;
        tx_valid_prev = tx_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_hour", alarm_hour, 0);
        chk("rst_min", alarm_minute, 0);
        chk("rst_txv", tx_valid, 0);
        chk("rst_txd", tx_data, 8'h00);
        chk("rst_set", alarm_set, 0);
        chk("rst_err", cmd_error, 0);

        // A07:30 CR
        send_str("A07:30"); send(8'h0D);
        chk("t1_set", alarm_set, 1);
        chk("t1_txv", tx_valid, 1);
        chk("t1_txd", tx_data, 8'h4B);
        chk("t1_hour", alarm_hour, 7);
        chk("t1_min", alarm_minute, 30);
        @(negedge clk);
        chk("t1_set_drop", alarm_set, 0);
        chk("t1_txv_drop", tx_valid, 0);

        // a23:59 LF, then out-of-range hour 24
        send_str("a23:59"); send(8'h0A);
        chk("t2_set", alarm_set, 1);
        chk("t2_txd", tx_data, 8'h4B);
        chk("t2_hour", alarm_hour, 23);
        chk("t2_min", alarm_minute, 59);
        @(negedge clk);
        send_str("A24:00"); send(8'h0D);
        chk("t2b_err", cmd_error, 1);
        chk("t2b_set", alarm_set, 0);
        chk("t2b_txv", tx_valid, 1);
        chk("t2b_txd", tx_data, 8'h45);
        chk("t2b_hour", alarm_hour, 23);
        chk("t2b_min", alarm_minute, 59);
        @(negedge clk);
        chk("t2b_txv_drop", tx_valid, 0);

        // Bad digit with back-pressure; an 'A' arriving in RESP must be dropped
        tx_ready = 1'b0;
        send_str("A1x:00"); send(8'h0D);
        chk("t3_err", cmd_error, 1);
        chk("t3_txv", tx_valid, 1);
        chk("t3_txd", tx_data, 8'h45);
        send(8'h41);
        chk("t3_err_once", cmd_error, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_hold_txv", tx_valid, 1);
            chk("t3_hold_txd", tx_data, 8'h45);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        chk("t3_txv_drop", tx_valid, 0);

        // Missing digit, same back-pressure
        tx_ready = 1'b0;
        send_str("A6:00"); send(8'h0D);
        chk("t3b_err", cmd_error, 1);
        chk("t3b_txd", tx_data, 8'h45);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3b_hold_txv", tx_valid, 1);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        chk("t3b_txv_drop", tx_valid, 0);
        // If the dropped 'A' had been accepted, this would complete a command
        send_str("12:00"); send(8'h0D);
        @(negedge clk);
        chk("t3_resp_cnt", resp_cnt, 5);
        chk("t3_set_cnt", set_cnt, 2);
        chk("t3_err_cnt", err_cnt, 3);

        // Timeout abort after A12 with 20 idle cycles
        send_str("A12");
        repeat (20) @(negedge clk);
        send_str(":00"); send(8'h0D);
        repeat (2) @(negedge clk);
        chk("t4_resp_cnt", resp_cnt, 5);
        chk("t4_set_cnt", set_cnt, 2);
        chk("t4_err_cnt", err_cnt, 3);
        send_str("A12:00"); send(8'h0D);
        chk("t4_set", alarm_set, 1);
        chk("t4_txd", tx_data, 8'h4B);
        chk("t4_hour", alarm_hour, 12);
        chk("t4_min", alarm_minute, 0);
        @(negedge clk);

        // Byte lands exactly on the expiry cycle in H2 (16th idle cycle)
        send_str("A1");
        repeat (15) @(negedge clk);
        send(8'h32);
        send_str(":45"); send(8'h0D);
        chk("t5_set", alarm_set, 1);
        chk("t5_hour", alarm_hour, 12);
        chk("t5_min", alarm_minute, 45);
        chk("t5_txd", tx_data, 8'h4B);
        @(negedge clk);

        // Reset mid-command
        send_str("A09:1");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_hour", alarm_hour, 0);
        chk("t6_min", alarm_minute, 0);
        chk("t6_txv", tx_valid, 0);
        chk("t6_txd", tx_data, 8'h00);
        send(8'h35); send(8'h0D);
        @(negedge clk);
        chk("t6_resp_cnt", resp_cnt, 7);
        send_str("A09:15"); send(8'h0D);
        chk("t6_set", alarm_set, 1);
        chk("t6b_hour", alarm_hour, 9);
        chk("t6b_min", alarm_minute, 15);
        chk("t6b_txd", tx_data, 8'h4B);
        @(negedge clk);
        chk("t6b_txv_drop", tx_valid, 0);
        chk("end_set_cnt", set_cnt, 5);
        chk("end_err_cnt", err_cnt, 3);
        chk("end_resp_cnt", resp_cnt, 8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
